// File: rtl/wbdbgbus_pkg.sv
// Shared constants and types for the UART debug bus.
// Frames are five bytes, most significant byte first.
package wbdbgbus_pkg;

    localparam int FRAME_BYTES = 5;

    localparam logic [3:0] CMD_RESET  = 4'b1111;
    localparam logic [3:0] RESP_INT_1 = 4'b1000;
    localparam logic [3:0] RESP_INT_2 = 4'b1001;
    localparam logic [3:0] RESP_INT_3 = 4'b1010;
    localparam logic [3:0] RESP_INT_4 = 4'b1011;

    typedef logic [39:0] frame_t;

    function automatic logic is_interrupt(input logic [3:0] code);
        return (code >= RESP_INT_1) && (code <= RESP_INT_4);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver, no reset; emits a one-cycle o_valid per byte.
// The synchronizer holds the inverted line so power-up zero reads idle.
module uart_rx #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       i_clk,
    input  logic       i_rx,
    output logic       o_valid,
    output logic [7:0] o_data
);
    localparam int CW = $clog2(CLKS_PER_BIT * 2) + 1;

    logic [1:0]    sync_n_q;
    logic          rx;
    logic          armed_q, armed_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;

    always_comb begin
        rx      = ~sync_n_q[1];
        armed_d = armed_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        if (!busy_q) begin
            if (rx) begin
                armed_d = 1'b1;
            end else if (armed_q) begin
                busy_d = 1'b1;
                cnt_d  = CW'(CLKS_PER_BIT + CLKS_PER_BIT / 2 - 1);
                idx_d  = '0;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            data_d = {rx, data_q[7:1]};
            cnt_d  = CW'(CLKS_PER_BIT - 1);
            if (idx_q == 3'd7) begin
                busy_d  = 1'b0;
                armed_d = 1'b0;
                valid_d = 1'b1;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        sync_n_q <= {sync_n_q[0], ~i_rx};
        armed_q  <= armed_d;
        busy_q   <= busy_d;
        valid_q  <= valid_d;
        cnt_q    <= cnt_d;
        idx_q    <= idx_d;
        data_q   <= data_d;
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, no reset; an all-zero power-up state is idle.
// o_ready is high only when no byte is on the line.
module uart_tx #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       i_clk,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;

    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]    bits_q, bits_d;
    logic [9:0]    shift_q, shift_d;

    always_comb begin
        baud_d  = baud_q;
        bits_d  = bits_q;
        shift_d = shift_q;
        if (bits_q == 4'd0) begin
            if (i_valid) begin
                shift_d = {1'b1, i_data, 1'b0};
                bits_d  = 4'd10;
                baud_d  = CW'(CLKS_PER_BIT - 1);
            end
        end else if (baud_q == '0) begin
            shift_d = {1'b1, shift_q[9:1]};
            bits_d  = bits_q - 4'd1;
            baud_d  = CW'(CLKS_PER_BIT - 1);
        end else begin
            baud_d = baud_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        baud_q  <= baud_d;
        bits_q  <= bits_d;
        shift_q <= shift_d;
    end

    assign o_ready = (bits_q == 4'd0);
    assign o_tx    = (bits_q == 4'd0) | shift_q[0];

endmodule

// File: rtl/wbdbgbus_frame_rx.sv
// Byte-to-frame assembler: the frame completes in the same cycle as its
// last byte; a partial frame idle for DROP_CLKS clocks is discarded.
module wbdbgbus_frame_rx
    import wbdbgbus_pkg::*;
#(
    parameter int DROP_CLKS = 2500000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    output logic        o_frame_valid,
    output logic [35:0] o_frame,
    output logic        o_partial
);
    localparam int TW = $clog2(DROP_CLKS) + 1;

    logic [2:0]      idx_q, idx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      b0_q, b0_d;
    logic [2:0][7:0] bn_q, bn_d;

    always_comb begin
        idx_d         = idx_q;
        timer_d       = timer_q;
        b0_d          = b0_q;
        bn_d          = bn_q;
        o_frame_valid = 1'b0;
        if (i_valid) begin
            timer_d = TW'(DROP_CLKS);
            if (idx_q == 3'(FRAME_BYTES - 1)) begin
                idx_d         = '0;
                o_frame_valid = 1'b1;
            end else begin
                if (idx_q == 3'd0) b0_d = i_data[3:0];
                else bn_d[2'(idx_q - 3'd1)] = i_data;
                idx_d = idx_q + 3'd1;
            end
        end else if (idx_q != 3'd0) begin
            if (timer_q <= TW'(1)) idx_d = '0;
            else timer_d = timer_q - TW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            idx_q   <= '0;
            timer_q <= '0;
            b0_q    <= '0;
            bn_q    <= '0;
        end else begin
            idx_q   <= idx_d;
            timer_q <= timer_d;
            b0_q    <= b0_d;
            bn_q    <= bn_d;
        end
    end

    assign o_frame   = {b0_q, bn_q[0], bn_q[1], bn_q[2], i_data};
    assign o_partial = (idx_q != 3'd0);

endmodule

// File: rtl/wbdbgbus_host.sv
// Host end of the UART debug bus: serializes commands into frames and
// splits received frames into responses and interrupt pulses.
module wbdbgbus_host
    import wbdbgbus_pkg::*;
#(
    parameter int CLK_FREQ  = 25000000,
    parameter int UART_BAUD = 9600,
    parameter int DROP_CLKS = 2500000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_tx,
    input  logic        i_rx,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [35:0] i_cmd_data,
    input  logic        i_bus_reset,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [35:0] o_resp_data,
    output logic [3:0]  o_interrupt,
    output logic        o_resp_overflow,
    output logic        o_busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / UART_BAUD;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

    state_t      state_q, state_d;
    logic [2:0]  k_q, k_d;
    frame_t      frame_q, frame_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        pend_q, pend_d;
    logic        resp_valid_q, resp_valid_d;
    logic [35:0] resp_data_q, resp_data_d;
    logic [3:0]  int_q, int_d;
    logic        ovf_q, ovf_d;

    logic        tx_ready, tx_free;
    logic        rx_valid, rx_partial, rx_frame_valid;
    logic [7:0]  rx_data;
    logic [35:0] rx_frame;
    logic [3:0]  code;

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .i_clk   (i_clk),
        .i_valid (tx_valid_q),
        .i_data  (tx_data_q),
        .o_ready (tx_ready),
        .o_tx    (o_tx)
    );

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .i_clk   (i_clk),
        .i_rx    (i_rx),
        .o_valid (rx_valid),
        .o_data  (rx_data)
    );

    wbdbgbus_frame_rx #(.DROP_CLKS(DROP_CLKS)) u_frame_rx (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (rx_valid),
        .i_data        (rx_data),
        .o_frame_valid (rx_frame_valid),
        .o_frame       (rx_frame),
        .o_partial     (rx_partial)
    );

    // tx_valid_q is checked too: uart_tx only drops ready the cycle after
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        frame_d     = frame_q;
        tx_valid_d  = 1'b0;
        tx_data_d   = tx_data_q;
        pend_d      = pend_q | i_bus_reset;
        tx_free     = tx_ready && !tx_valid_q;
        o_cmd_ready = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (tx_free) begin
                    if (pend_q) begin
                        frame_d = {4'h0, CMD_RESET, 32'h0};
                        pend_d  = i_bus_reset;
                        state_d = S_LOAD;
                    end else begin
                        o_cmd_ready = i_rst_n;
                        if (i_cmd_valid) begin
                            frame_d = {4'h0, i_cmd_data};
                            state_d = S_LOAD;
                        end
                    end
                end
            end
            S_LOAD: begin
                k_d     = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (tx_free) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = frame_q[39:32];
                    frame_d    = {frame_q[31:0], 8'h00};
                    if (k_q == 3'(FRAME_BYTES - 1)) state_d = S_IDLE;
                    else k_d = k_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        code         = rx_frame[35:32];
        resp_valid_d = resp_valid_q && !i_resp_ready;
        resp_data_d  = resp_data_q;
        int_d        = '0;
        ovf_d        = ovf_q;
        if (rx_frame_valid) begin
            if (is_interrupt(code)) begin
                int_d[2'(code - RESP_INT_1)] = 1'b1;
            end else if (!resp_valid_q || i_resp_ready) begin
                resp_valid_d = 1'b1;
                resp_data_d  = rx_frame;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            frame_q      <= '0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            pend_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            int_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            frame_q      <= frame_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            pend_q       <= pend_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            int_q        <= int_d;
            ovf_q        <= ovf_d;
        end
    end

    assign o_resp_valid    = resp_valid_q;
    assign o_resp_data     = resp_data_q;
    assign o_interrupt     = int_q;
    assign o_resp_overflow = ovf_q;
    assign o_busy          = (state_q != S_IDLE) || rx_partial || pend_q;

endmodule

// File: doc/wbdbgbus_host.md
Name: wbdbgbus_host

Overview:
- Initiator end of the UART debug-bus protocol: the host side of the bus, for on-chip use (test harness, supervisor core).
- Accepts 36-bit commands, serializes each as a 5-byte frame over UART, and reassembles the 5-byte response frames from the target bridge.
- Interrupt frames are separated out as pulses. All other responses go to a valid/ready output.
- Instantiates the existing uart_tx and uart_rx modules.

Parameters:
- CLK_FREQ, 25000000, system clock in Hz.
- UART_BAUD, 9600, line baud rate.
- DROP_CLKS, 2500000, idle clocks after which a partial response frame is discarded.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  synchronous active-low reset
- o_tx  out  1  UART line to target (idle high)
- i_rx  in  1  UART line from target
- i_cmd_valid  in  1  command offered
- o_cmd_ready  out  1  command accepted when valid&&ready
- i_cmd_data  in  36  command {opcode[35:32], payload[31:0]}
- i_bus_reset  in  1  pulse: send a reset frame
- o_resp_valid  out  1  response held
- i_resp_ready  in  1  consumer takes response
- o_resp_data  out  36  response {code[35:32], payload[31:0]}
- o_interrupt  out  4  one-cycle pulse per received interrupt frame, bit n = INT_(n+1)
- o_resp_overflow  out  1  sticky: a response was dropped
- o_busy  out  1  TX frame in progress or RX frame partial

Behaviour:
- Reset values (i_rst_n=0 at a clock edge): o_cmd_ready=0, o_resp_valid=0, o_resp_data=0, o_interrupt=0, o_resp_overflow=0, o_busy=0. TX FSM goes to IDLE and the RX byte index to 0; pending reset request and held command are cleared.
- uart_tx/uart_rx have no reset. A byte already on the line completes; TX FSM does not start a frame until uart_tx ready=1.
- TX FSM states: IDLE, LOAD, SEND(k=0..4).
- IDLE, o_cmd_ready=1 when uart_tx ready and no reset request is pending.
  - Handshake captures frame {4'b0000, i_cmd_data}; go to LOAD.
  - A pending reset request has priority over i_cmd_valid (o_cmd_ready=0 that cycle). It loads frame {4'h0, 4'hF, 32'h0}.
- i_bus_reset is latched into a pending flag in any state. It is sent after the current frame completes, never interleaved mid-frame.
- SEND(k): when uart_tx ready && !tx_valid_q, present byte k (k=0 is bits[39:32], MSB first) with a one-cycle valid. k==4 returns to IDLE.
- o_cmd_ready is low from handshake until back in IDLE; never two commands per frame.
- RX assembler:
  - On each uart_rx valid: store byte at index, increment index, reload drop timer to DROP_CLKS.
  - When index>0 and no byte arrives: decrement the timer; at 1, index goes to 0 and the partial frame is discarded silently.
  - On the 5th byte the frame completes the same cycle as that byte (byte 0 upper nibble is ignored). Classify on code[35:32]:
    - 4'b1000..4'b1011: pulse o_interrupt[code-8] for 1 cycle the next cycle; not sent to the resp port.
    - Otherwise: if !o_resp_valid, or i_resp_ready in the same cycle, load o_resp_data and assert o_resp_valid the next cycle.
    - Otherwise: drop the frame and set o_resp_overflow; it is cleared only by reset.
- Response port: o_resp_valid holds until i_resp_ready; o_resp_data stable while valid. Latency is 1 cycle from the last byte's rx valid to o_resp_valid.
- o_busy = (TX state != IDLE) || (RX index != 0) || reset pending.
- Drop timer width: $clog2(DROP_CLKS)+1 bits.

Decomposition:
- Package wbdbgbus_pkg holds:
  - FRAME_BYTES=5
  - CMD_RESET=4'b1111
  - RESP_INT_1..4 = 4'b1000..4'b1011
  - typedef frame_t (40-bit)
  - function is_interrupt(code)
- One sub-module, wbdbgbus_frame_rx: byte-to-frame assembler with drop timer, with a frame-valid output. It is reusable by the bridge later.

Test Plan:
- Bench runs CLK_FREQ=1000000, UART_BAUD=100000 (10 clocks per bit).
- Command 36'h2_1234_5678 → line carries 00,02... precisely: bytes 0x02,0x12,0x34,0x56,0x78. o_cmd_ready low throughout, high after the last stop bit.
- i_bus_reset pulsed during frame 36'h1_0000_0004 → that frame completes, then bytes 0x0F,0x00,0x00,0x00,0x00; command offered meanwhile waits.
- Target sends 0x03,0xDE,0xAD,0xBE,0xEF with i_resp_ready=0 → o_resp_valid=1, data 36'h3_DEAD_BEEF held. A second frame then sets o_resp_overflow and data stays DEADBEEF.
- Target sends 0x0A,0,0,0,0 → o_interrupt=4'b0100 for exactly 1 cycle; o_resp_valid stays 0.
- Send 3 bytes then idle DROP_CLKS+5 clocks, then full frame 0x04,0x00,0x00,0x00,0x01 → only 36'h4_0000_0001 delivered; o_busy returns 0.
- Assert i_rst_n=0 mid-RX-frame and mid-TX → all outputs zero next cycle; the next command is sent only after uart_tx ready, with an intact frame.
